// File: rtl/bsg_core_intf_trace_rom.sv
// rtl/bsg_core_intf_trace_rom.sv - built-in 8-entry core/cache trace ROM plus core 0/1/2 wrappers
// Define TRACE_ROM_ERR_EN to add the sticky out-of-range flag; otherwise err_o is tied low.
module bsg_core_intf_trace_rom #(
  parameter int width_p      = 73,
  parameter int addr_width_p = 15,
  parameter int core_id_p    = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [addr_width_p-1:0] addr_i,
  output logic [width_p-1:0]      data_o,
  output logic                    err_o
);

  localparam logic [3:0] op_wait_lp = 4'd0;
  localparam logic [3:0] op_send_lp = 4'd1;
  localparam logic [3:0] op_recv_lp = 4'd2;
  localparam logic [3:0] op_done_lp = 4'd3;

  function automatic logic [31:0] pick_a(input int id);
    case (id)
      1:       return 32'hCAFEF00D;
      2:       return 32'hA5A55A5A;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic logic [31:0] pick_v(input int id);
    case (id)
      1:       return 32'h12345678;
      2:       return 32'hFFFFFFFF;
      default: return 32'h00000001;
    endcase
  endfunction

  // Each core owns its own 256-byte window so traces never alias.
  localparam logic [31:0] base_lp = 32'(core_id_p * 256);
  localparam logic [31:0] a_lp    = pick_a(core_id_p);
  localparam logic [31:0] v_lp    = pick_v(core_id_p);

  function automatic logic [68:0] send_pkt(input logic we, input logic [31:0] addr,
                                            input logic [31:0] wdata);
    return {4'b0, we, addr, wdata};
  endfunction

  function automatic logic [68:0] recv_pkt(input logic [31:0] rdata);
    return {37'b0, rdata};
  endfunction

  logic        out_of_range;
  logic [2:0]  idx;
  logic [3:0]  op;
  logic [68:0] payload;

  assign out_of_range = (addr_i >> 3) != '0;
  assign idx          = addr_i[2:0];

  always_comb begin
    op      = op_done_lp;
    payload = '0;
    if (!out_of_range) begin
      case (idx)
        3'd0: op = op_wait_lp;
        3'd1: begin op = op_send_lp; payload = send_pkt(1'b1, base_lp, a_lp); end
        3'd2: begin op = op_send_lp; payload = send_pkt(1'b1, base_lp + 32'd4, v_lp); end
        3'd3: begin op = op_send_lp; payload = send_pkt(1'b0, base_lp, 32'd0); end
        3'd4: begin op = op_recv_lp; payload = recv_pkt(a_lp); end
        3'd5: begin op = op_send_lp; payload = send_pkt(1'b0, base_lp + 32'd4, 32'd0); end
        3'd6: begin op = op_recv_lp; payload = recv_pkt(v_lp); end
        default: begin op = op_done_lp; payload = '0; end
      endcase
    end
  end

  assign data_o = {op, payload};

`ifdef TRACE_ROM_ERR_EN
  logic err_d, err_q;

  always_comb begin
    err_d = err_q | out_of_range;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk_i ^ reset_i;
  assign err_o          = 1'b0;
`endif

endmodule

module bsg_core_intf_trace_rom0 #(
  parameter int width_p      = 73,
  parameter int addr_width_p = 15
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [addr_width_p-1:0] addr_i,
  output logic [width_p-1:0]      data_o,
  output logic                    err_o
);
  bsg_core_intf_trace_rom #(.width_p(width_p), .addr_width_p(addr_width_p), .core_id_p(0)) rom (
    .clk_i(clk_i), .reset_i(reset_i), .addr_i(addr_i), .data_o(data_o), .err_o(err_o)
  );
endmodule

module bsg_core_intf_trace_rom1 #(
  parameter int width_p      = 73,
  parameter int addr_width_p = 15
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [addr_width_p-1:0] addr_i,
  output logic [width_p-1:0]      data_o,
  output logic                    err_o
);
  bsg_core_intf_trace_rom #(.width_p(width_p), .addr_width_p(addr_width_p), .core_id_p(1)) rom (
    .clk_i(clk_i), .reset_i(reset_i), .addr_i(addr_i), .data_o(data_o), .err_o(err_o)
  );
endmodule

module bsg_core_intf_trace_rom2 #(
  parameter int width_p      = 73,
  parameter int addr_width_p = 15
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [addr_width_p-1:0] addr_i,
  output logic [width_p-1:0]      data_o,
  output logic                    err_o
);
  bsg_core_intf_trace_rom #(.width_p(width_p), .addr_width_p(addr_width_p), .core_id_p(2)) rom (
    .clk_i(clk_i), .reset_i(reset_i), .addr_i(addr_i), .data_o(data_o), .err_o(err_o)
  );
endmodule

// File: tb/tb_bsg_core_intf_trace_rom.sv
// tb/tb_bsg_core_intf_trace_rom.sv - directed check of all three trace ROMs and the err_o flag
// Build with or without TRACE_ROM_ERR_EN; the err_o expectations follow the macro.
module tb_bsg_core_intf_trace_rom;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] addr;
  logic [72:0] d0, d1, d2;
  logic        e0, e1, e2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  bsg_core_intf_trace_rom #(.width_p(73), .addr_width_p(15), .core_id_p(0)) u0 (
    .clk_i(clk), .reset_i(reset), .addr_i(addr), .data_o(d0), .err_o(e0)
  );
  bsg_core_intf_trace_rom1 #(.width_p(73), .addr_width_p(15)) u1 (
    .clk_i(clk), .reset_i(reset), .addr_i(addr), .data_o(d1), .err_o(e1)
  );
  bsg_core_intf_trace_rom2 #(.width_p(73), .addr_width_p(15)) u2 (
    .clk_i(clk), .reset_i(reset), .addr_i(addr), .data_o(d2), .err_o(e2)
  );

  task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [72:0] snd(input logic we, input logic [31:0] a, input logic [31:0] w);
    return {4'h1, 4'h0, we, a, w};
  endfunction

  function automatic logic [72:0] rcv(input logic [31:0] r);
    return {4'h2, 37'b0, r};
  endfunction

  localparam logic [72:0] done_c = {4'h3, 69'h0};
  localparam logic [72:0] wait_c = 73'h0;

  logic [72:0] exp_tab [3][8];
  logic [72:0] got;

  function automatic logic [72:0] dout(input int c);
    case (c)
      0:       return d0;
      1:       return d1;
      default: return d2;
    endcase
  endfunction

  function automatic logic eout(input int c);
    case (c)
      0:       return e0;
      1:       return e1;
      default: return e2;
    endcase
  endfunction

  initial begin
    exp_tab[0] = '{wait_c, snd(1'b1, 32'h0, 32'hDEADBEEF), snd(1'b1, 32'h4, 32'h1),
                   snd(1'b0, 32'h0, 32'h0), rcv(32'hDEADBEEF), snd(1'b0, 32'h4, 32'h0),
                   rcv(32'h1), done_c};
    exp_tab[1] = '{wait_c, snd(1'b1, 32'h100, 32'hCAFEF00D), snd(1'b1, 32'h104, 32'h12345678),
                   snd(1'b0, 32'h100, 32'h0), rcv(32'hCAFEF00D), snd(1'b0, 32'h104, 32'h0),
                   rcv(32'h12345678), done_c};
    exp_tab[2] = '{wait_c, snd(1'b1, 32'h200, 32'hA5A55A5A), snd(1'b1, 32'h204, 32'hFFFFFFFF),
                   snd(1'b0, 32'h200, 32'h0), rcv(32'hA5A55A5A), snd(1'b0, 32'h204, 32'h0),
                   rcv(32'hFFFFFFFF), done_c};

    reset = 1'b1;
    addr  = 15'd0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("reset_err_c%0d", c), 73'(eout(c)), 73'd0);
      check($sformatf("reset_data_c%0d", c), dout(c), wait_c);
    end
    addr = 15'd1;
    #1;
    check("reset_data_c0_a1", d0, {4'h1, 4'h0, 1'b1, 32'h00000000, 32'hDEADBEEF});

    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      addr = 15'(a);
      #1;
      for (int c = 0; c < 3; c++) begin
        got = dout(c);
        check($sformatf("entry_c%0d_a%0d", c, a), got, exp_tab[c][a]);
        check($sformatf("opcode_legal_c%0d_a%0d", c, a), 73'(got[72:69] <= 4'd3), 73'd1);
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) check($sformatf("err_inrange_c%0d", c), 73'(eout(c)), 73'd0);

    check("c1_a4_literal", exp_tab[1][4], {4'h2, 37'b0, 32'hCAFEF00D});
    addr = 15'd5;
    #1;
    check("c1_a5_read104", d1, {4'h1, 4'h0, 1'b0, 32'h00000104, 32'h0});

    @(negedge clk);
    addr  = 15'd4;
    reset = 1'b1;
    #1;
    check("reset_mid_trace_c1", d1, rcv(32'hCAFEF00D));
    reset = 1'b0;
    #1;
    check("release_mid_trace_c1", d1, rcv(32'hCAFEF00D));
    addr = 15'd6;
    #1;
    check("after_release_c2_a6", d2, rcv(32'hFFFFFFFF));

`ifdef TRACE_ROM_ERR_EN
    @(negedge clk);
    addr = 15'd9;
    #1;
    check("err_before_edge", {70'd0, e0, e1, e2}, 73'd0);
    @(posedge clk);
    #1;
    check("err_set", {70'd0, e0, e1, e2}, 73'b111);
    addr = 15'd0;
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", {70'd0, e0, e1, e2}, 73'b111);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("err_async_clear", {70'd0, e0, e1, e2}, 73'd0);
    addr = 15'd9;
    repeat (3) @(posedge clk);
    #1;
    check("err_held_in_reset", {70'd0, e0, e1, e2}, 73'd0);
    @(negedge clk);
    addr  = 15'd0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("err_clear_after_reset", {70'd0, e0, e1, e2}, 73'd0);
`endif

    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      addr = 15'(a);
      #1;
      if (a >= 8) begin
        check($sformatf("oor_c0_a%0d", a), d0, done_c);
        check($sformatf("oor_c2_a%0d", a), d2, done_c);
      end
`ifndef TRACE_ROM_ERR_EN
      @(posedge clk);
      #1;
      check($sformatf("err_tied_a%0d", a), {70'd0, e0, e1, e2}, 73'd0);
`endif
    end
    addr = 15'h4001;
    #1;
    check("oor_high_bit_c1", d1, done_c);
    addr = 15'h7FFF;
    #1;
    check("oor_max_c2", d2, done_c);
    addr = 15'd100;
    #1;
    check("c2_a100_done", d2, done_c);

`ifdef TRACE_ROM_ERR_EN
    @(posedge clk);
    #1;
    check("err_after_sweep", {70'd0, e0, e1, e2}, 73'b111);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
